// File: rtl/cnn_pkg.sv
// Shared types and helpers for the cnn_accel 1-D convolution processing element.
package cnn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_LOAD_FILTER = 3'd1,
        ST_LOAD_ROW    = 3'd2,
        ST_COMPUTE     = 3'd3,
        ST_PSUM        = 3'd4,
        ST_WRITE       = 3'd5
    } cnn_state_e;

    // IFmap word flags sit in the two MSBs above the unsigned data field.
    function automatic int start_bit(input int width);
        return width - 1;
    endfunction

    function automatic int end_bit(input int width);
        return width - 2;
    endfunction

    function automatic int unsigned norm_stride(input int unsigned stride);
        return (stride == 0) ? 1 : stride;
    endfunction

endpackage

// File: rtl/cnn_fifo.sv
// Parameterized circular FIFO with count/full/empty; head word is read combinationally.
module cnn_fifo
    import cnn_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // NOTE: storage is deliberately left out of reset; emptiness is defined by the count, so clearing the array would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/cnn_accel.sv
// 1-D convolution processing element: FIFO-fed filter/IFmap scratchpads, serial MAC, result FIFO.
// Optional partial-sum FIFO and PSUM state are compiled in when CNN_PSUM_EN is defined.
module cnn_accel
    import cnn_pkg::*;
#(
    parameter int IFMAP_BUFFER_WIDTH      = 18,
    parameter int IF_ADDR_WIDTH           = 4,
    parameter int IF_BUFFER_COLUMNS       = 12,
    parameter int IF_BUFFER_PAR_WRITE     = 1,
    parameter int IF_PAD_LENGTH           = 12,
    parameter int FILTER_BUFFER_WIDTH     = 16,
    parameter int FILTER_SIZE_WIDTH       = 5,
    parameter int FILTER_ADDR_WIDTH       = 4,
    parameter int FILTER_PAD_LENGTH       = 16,
    parameter int FILTER_BUFFER_COLUMNS   = 16,
    parameter int FILTER_BUFFER_PAR_WRITE = 1,
    parameter int RESULT_BUFFER_WIDTH     = 16,
    parameter int RESULT_BUFFER_PAR_READ  = 1,
    parameter int RESULT_BUFFER_COLUMNS   = 64,
    parameter int ADD_OUT_WIDTH           = 16,
    parameter int STRIDE_WIDTH            = 5,
    parameter int MULT_WIDTH              = 32,
    parameter int I_WIDTH                 = 5,
    parameter int PSUM_ADDR_WIDTH         = 4,
    parameter int PSUM_PAD_LENGTH         = 16,
    parameter int PSUM_SPAD_WIDTH         = 16,
    parameter int PSUM_BUFFER_WIDTH       = 16,
    parameter int PSUM_BUFFER_COLUMNS     = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [STRIDE_WIDTH-1:0]        stride,
    input  logic [FILTER_SIZE_WIDTH-1:0]   filter_size,
    input  logic                           psum_mode,
    output logic                           stall_signal,
    input  logic [IFMAP_BUFFER_WIDTH-1:0]  IFmap_buffer_in,
    input  logic                           IFmap_buffer_write_enable,
    output logic                           IFmap_buffer_full,
    output logic                           IFmap_buffer_ready,
    input  logic [FILTER_BUFFER_WIDTH-1:0] filter_buffer_in,
    input  logic                           filter_buffer_write_enable,
    output logic                           filter_buffer_full,
    output logic                           filter_buffer_ready,
    output logic [RESULT_BUFFER_WIDTH-1:0] result_buffer_out,
    input  logic                           result_buffer_read_enable,
    output logic                           result_buffer_empty,
    output logic                           result_buffer_valid,
    input  logic [PSUM_BUFFER_WIDTH-1:0]   psum_buffer_in,
    input  logic                           psum_buffer_wen,
    output logic                           psum_buffer_ready
);

    localparam int DATA_W    = IFMAP_BUFFER_WIDTH - 2;
    localparam int START_BIT = start_bit(IFMAP_BUFFER_WIDTH);
    localparam int END_BIT   = end_bit(IFMAP_BUFFER_WIDTH);
    localparam int LEN_W     = IF_ADDR_WIDTH + 1;
    localparam int CMP_W     = 8;
    localparam int unused_cfg = IF_BUFFER_PAR_WRITE + FILTER_BUFFER_PAR_WRITE + RESULT_BUFFER_PAR_READ
                              + PSUM_ADDR_WIDTH + PSUM_PAD_LENGTH + PSUM_SPAD_WIDTH + PSUM_BUFFER_COLUMNS;

    cnn_state_e                     state_q, state_d;
    logic [STRIDE_WIDTH-1:0]        stride_q, stride_d;
    logic [FILTER_SIZE_WIDTH-1:0]   fsize_q, fsize_d;
    logic [FILTER_SIZE_WIDTH-1:0]   k_q, k_d;
    logic [LEN_W-1:0]               row_len_q, row_len_d;
    logic [I_WIDTH-1:0]             pos_q, pos_d;
    logic [ADD_OUT_WIDTH-1:0]       acc_q, acc_d;
    logic [RESULT_BUFFER_WIDTH-1:0] res_out_q;
    logic                           res_valid_q;
    logic                           if_we_q, f_we_q, res_re_q;

    logic [DATA_W-1:0]              ifpad_q [IF_PAD_LENGTH];
    logic [FILTER_BUFFER_WIDTH-1:0] fpad_q  [FILTER_PAD_LENGTH];

    logic [IFMAP_BUFFER_WIDTH-1:0]  if_head;
    logic [FILTER_BUFFER_WIDTH-1:0] f_head;
    logic [RESULT_BUFFER_WIDTH-1:0] res_head;
    logic [PSUM_BUFFER_WIDTH-1:0]   psum_head;
    logic                           if_empty, f_empty, res_full, res_empty, psum_empty;
    logic                           if_pop, f_pop, res_push, res_pop, psum_pop, psum_sel;
    logic                           if_push, f_push, res_rd_edge;
    logic [$clog2(IF_BUFFER_COLUMNS+1)-1:0]     if_cnt;
    logic [$clog2(FILTER_BUFFER_COLUMNS+1)-1:0] f_cnt;
    logic [$clog2(RESULT_BUFFER_COLUMNS+1)-1:0] res_cnt;
    logic                           unused_counts;

    logic [IF_ADDR_WIDTH-1:0]       if_wr_addr, if_rd_addr;
    logic [CMP_W-1:0]               next_pos_w, next_end_w;
    logic                           stall;

    // Each enable performs one transfer on its rising edge only.
    assign if_push     = IFmap_buffer_write_enable & ~if_we_q;
    assign f_push      = filter_buffer_write_enable & ~f_we_q;
    assign res_rd_edge = result_buffer_read_enable & ~res_re_q;
    assign res_pop     = res_rd_edge & ~res_empty;

    cnn_fifo #(.WIDTH(IFMAP_BUFFER_WIDTH), .DEPTH(IF_BUFFER_COLUMNS)) u_if_fifo (
        .clk(clk), .reset(reset), .push_i(if_push), .push_data_i(IFmap_buffer_in), .pop_i(if_pop),
        .head_o(if_head), .count_o(if_cnt), .full_o(IFmap_buffer_full), .empty_o(if_empty)
    );

    cnn_fifo #(.WIDTH(FILTER_BUFFER_WIDTH), .DEPTH(FILTER_BUFFER_COLUMNS)) u_f_fifo (
        .clk(clk), .reset(reset), .push_i(f_push), .push_data_i(filter_buffer_in), .pop_i(f_pop),
        .head_o(f_head), .count_o(f_cnt), .full_o(filter_buffer_full), .empty_o(f_empty)
    );

    cnn_fifo #(.WIDTH(RESULT_BUFFER_WIDTH), .DEPTH(RESULT_BUFFER_COLUMNS)) u_res_fifo (
        .clk(clk), .reset(reset), .push_i(res_push), .push_data_i(RESULT_BUFFER_WIDTH'(acc_q)),
        .pop_i(res_pop), .head_o(res_head), .count_o(res_cnt), .full_o(res_full), .empty_o(res_empty)
    );

    assign IFmap_buffer_ready  = ~IFmap_buffer_full;
    assign filter_buffer_ready = ~filter_buffer_full;
    assign result_buffer_empty = res_empty;
    assign result_buffer_out   = res_out_q;
    assign result_buffer_valid = res_valid_q;
    assign stall_signal        = stall;
    assign unused_counts       = ^{if_cnt, f_cnt, res_cnt};

`ifdef CNN_PSUM_EN
    logic psum_we_q;
    logic psum_push;
    logic psum_full;
    logic [$clog2(PSUM_BUFFER_COLUMNS+1)-1:0] psum_cnt;
    logic unused_psum_cnt;

    assign psum_push = psum_buffer_wen & ~psum_we_q;

    cnn_fifo #(.WIDTH(PSUM_BUFFER_WIDTH), .DEPTH(PSUM_BUFFER_COLUMNS)) u_psum_fifo (
        .clk(clk), .reset(reset), .push_i(psum_push), .push_data_i(psum_buffer_in), .pop_i(psum_pop),
        .head_o(psum_head), .count_o(psum_cnt), .full_o(psum_full), .empty_o(psum_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            psum_we_q <= 1'b0;
        end else begin
            psum_we_q <= psum_buffer_wen;
        end
    end

    assign psum_buffer_ready = ~psum_full;
    assign psum_sel          = psum_mode;
    assign unused_psum_cnt   = ^psum_cnt;
`else
    logic unused_psum;

    assign psum_head         = '0;
    assign psum_empty        = 1'b1;
    assign psum_buffer_ready = 1'b0;
    assign psum_sel          = 1'b0;
    assign unused_psum       = ^{psum_buffer_in, psum_buffer_wen, psum_mode, psum_pop};
`endif

    assign if_rd_addr = IF_ADDR_WIDTH'(pos_q + k_q);
    assign next_pos_w = CMP_W'(pos_q) + CMP_W'(stride_q);
    assign next_end_w = next_pos_w + CMP_W'(fsize_q);

    // NOTE: every variable gets a default before the case so no path leaves one unassigned, which would infer a latch.
    always_comb begin
        state_d    = state_q;
        stride_d   = stride_q;
        fsize_d    = fsize_q;
        k_d        = k_q;
        row_len_d  = row_len_q;
        pos_d      = pos_q;
        acc_d      = acc_q;
        stall      = 1'b0;
        f_pop      = 1'b0;
        if_pop     = 1'b0;
        psum_pop   = 1'b0;
        res_push   = 1'b0;
        if_wr_addr = if_head[START_BIT] ? '0 : row_len_q[IF_ADDR_WIDTH-1:0];

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    stride_d = STRIDE_WIDTH'(norm_stride(32'(stride)));
                    fsize_d  = filter_size;
                    k_d      = '0;
                    state_d  = ST_LOAD_FILTER;
                end
            end
            ST_LOAD_FILTER: begin
                if (fsize_q == '0) begin
                    row_len_d = '0;
                    state_d   = ST_LOAD_ROW;
                end else if (f_empty) begin
                    stall = 1'b1;
                end else begin
                    f_pop = 1'b1;
                    if (k_q == fsize_q - 1'b1) begin
                        k_d       = '0;
                        row_len_d = '0;
                        state_d   = ST_LOAD_ROW;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            ST_LOAD_ROW: begin
                if (if_empty) begin
                    stall = 1'b1;
                end else begin
                    if_pop    = 1'b1;
                    row_len_d = if_head[START_BIT] ? LEN_W'(1) : row_len_q + 1'b1;
                    if (if_head[END_BIT] || row_len_d == LEN_W'(IF_PAD_LENGTH)) begin
                        pos_d = '0;
                        k_d   = '0;
                        acc_d = '0;
                        // Rows too short for even one window go straight to the next filter.
                        if (fsize_q != '0 && CMP_W'(fsize_q) <= CMP_W'(row_len_d)) begin
                            state_d = ST_COMPUTE;
                        end else begin
                            state_d = ST_LOAD_FILTER;
                        end
                    end
                end
            end
            ST_COMPUTE: begin
                acc_d = acc_q + ADD_OUT_WIDTH'(MULT_WIDTH'(ifpad_q[if_rd_addr])
                                             * MULT_WIDTH'(fpad_q[k_q[FILTER_ADDR_WIDTH-1:0]]));
                if (k_q == fsize_q - 1'b1) begin
                    k_d     = '0;
                    state_d = psum_sel ? ST_PSUM : ST_WRITE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_PSUM: begin
                if (psum_empty) begin
                    stall = 1'b1;
                end else begin
                    psum_pop = 1'b1;
                    acc_d    = acc_q + ADD_OUT_WIDTH'(psum_head);
                    state_d  = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (res_full) begin
                    stall = 1'b1;
                end else begin
                    res_push = 1'b1;
                    k_d      = '0;
                    if (next_end_w <= CMP_W'(row_len_q)) begin
                        pos_d   = I_WIDTH'(next_pos_w);
                        acc_d   = '0;
                        state_d = ST_COMPUTE;
                    end else begin
                        state_d = ST_LOAD_FILTER;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (f_pop) begin
            fpad_q[k_q[FILTER_ADDR_WIDTH-1:0]] <= f_head;
        end
        if (if_pop) begin
            ifpad_q[if_wr_addr] <= if_head[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            stride_q    <= STRIDE_WIDTH'(1);
            fsize_q     <= '0;
            k_q         <= '0;
            row_len_q   <= '0;
            pos_q       <= '0;
            acc_q       <= '0;
            res_out_q   <= '0;
            res_valid_q <= 1'b0;
            if_we_q     <= 1'b0;
            f_we_q      <= 1'b0;
            res_re_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            stride_q  <= stride_d;
            fsize_q   <= fsize_d;
            k_q       <= k_d;
            row_len_q <= row_len_d;
            pos_q     <= pos_d;
            acc_q     <= acc_d;
            if_we_q   <= IFmap_buffer_write_enable;
            f_we_q    <= filter_buffer_write_enable;
            res_re_q  <= result_buffer_read_enable;
            if (res_pop) begin
                res_out_q   <= res_head;
                res_valid_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cnn_accel.sv
// Self-checking bench for cnn_accel: directed and randomized rows against a behavioural convolution model.
module tb_cnn_accel;

    localparam int IW = 18;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [4:0]    stride;
    logic [4:0]    filter_size;
    logic          psum_mode;
    logic          stall_signal;
    logic [IW-1:0] IFmap_buffer_in;
    logic          IFmap_buffer_write_enable;
    logic          IFmap_buffer_full;
    logic          IFmap_buffer_ready;
    logic [15:0]   filter_buffer_in;
    logic          filter_buffer_write_enable;
    logic          filter_buffer_full;
    logic          filter_buffer_ready;
    logic [15:0]   result_buffer_out;
    logic          result_buffer_read_enable;
    logic          result_buffer_empty;
    logic          result_buffer_valid;
    logic [15:0]   psum_buffer_in;
    logic          psum_buffer_wen;
    logic          psum_buffer_ready;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] filt_q[$];
    logic [15:0] row_q[$];
    logic [15:0] psum_q[$];
    logic [15:0] exp_q[$];

`ifdef CNN_PSUM_EN
    localparam bit PSUM_BUILT = 1'b1;
`else
    localparam bit PSUM_BUILT = 1'b0;
`endif

    cnn_accel dut (
        .clk(clk), .reset(reset), .start(start), .stride(stride), .filter_size(filter_size),
        .psum_mode(psum_mode), .stall_signal(stall_signal),
        .IFmap_buffer_in(IFmap_buffer_in), .IFmap_buffer_write_enable(IFmap_buffer_write_enable),
        .IFmap_buffer_full(IFmap_buffer_full), .IFmap_buffer_ready(IFmap_buffer_ready),
        .filter_buffer_in(filter_buffer_in), .filter_buffer_write_enable(filter_buffer_write_enable),
        .filter_buffer_full(filter_buffer_full), .filter_buffer_ready(filter_buffer_ready),
        .result_buffer_out(result_buffer_out), .result_buffer_read_enable(result_buffer_read_enable),
        .result_buffer_empty(result_buffer_empty), .result_buffer_valid(result_buffer_valid),
        .psum_buffer_in(psum_buffer_in), .psum_buffer_wen(psum_buffer_wen),
        .psum_buffer_ready(psum_buffer_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: slide the window in plain arithmetic, truncating each sum to 16 bits.
    function automatic void build_expected(input int fs, input int st, input bit use_psum);
        int s;
        int len;
        int pi;
        longint sum;
        s   = (st == 0) ? 1 : st;
        len = row_q.size();
        pi  = 0;
        exp_q.delete();
        if (fs > 0) begin
            for (int p = 0; p + fs <= len; p += s) begin
                sum = 0;
                for (int k = 0; k < fs; k++) begin
                    sum += longint'(row_q[p + k]) * longint'(filt_q[k]);
                end
                if (use_psum) begin
                    sum += longint'(psum_q[pi]);
                    pi++;
                end
                exp_q.push_back(16'(sum));
            end
        end
    endfunction

    task automatic apply_reset();
        start = 0; stride = 0; filter_size = 0; psum_mode = 0;
        IFmap_buffer_in = '0; IFmap_buffer_write_enable = 0;
        filter_buffer_in = '0; filter_buffer_write_enable = 0;
        result_buffer_read_enable = 0; psum_buffer_in = '0; psum_buffer_wen = 0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_ifmap(input logic [IW-1:0] w);
        @(negedge clk);
        IFmap_buffer_in = w;
        IFmap_buffer_write_enable = 1'b1;
        @(negedge clk);
        IFmap_buffer_write_enable = 1'b0;
    endtask

    task automatic write_ifmap(input logic [IW-1:0] w);
        int n = 0;
        while (!IFmap_buffer_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check("ifmap_ready_timeout", 0, 1);
        pulse_ifmap(w);
    endtask

    task automatic write_filter(input logic [15:0] w);
        int n = 0;
        while (!filter_buffer_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check("filter_ready_timeout", 0, 1);
        @(negedge clk);
        filter_buffer_in = w;
        filter_buffer_write_enable = 1'b1;
        @(negedge clk);
        filter_buffer_write_enable = 1'b0;
    endtask

    task automatic write_psum(input logic [15:0] w);
        @(negedge clk);
        psum_buffer_in = w;
        psum_buffer_wen = 1'b1;
        @(negedge clk);
        psum_buffer_wen = 1'b0;
    endtask

    task automatic read_result(output logic [15:0] v);
        int n = 0;
        while (result_buffer_empty && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check("result_timeout", 0, 1);
        @(negedge clk);
        result_buffer_read_enable = 1'b1;
        @(negedge clk);
        result_buffer_read_enable = 1'b0;
        v = result_buffer_out;
    endtask

    task automatic pulse_start(input int fs, input int st);
        filter_size = 5'(fs);
        stride = 5'(st);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_row();
        int len = row_q.size();
        for (int i = 0; i < len; i++) begin
            write_ifmap({1'(i == 0), 1'(i == len - 1), row_q[i]});
        end
    endtask

    task automatic set_basic_data();
        filt_q = '{16'd1, 16'd1, 16'd1, 16'd1};
        row_q.delete();
        for (int i = 1; i <= 8; i++) row_q.push_back(16'(i));
    endtask

    task automatic run_case(input string name, input int fs, input int st, input bit pm);
        logic [15:0] got;
        apply_reset();
        psum_mode = pm;
        build_expected(fs, st, 1'b0);
        pulse_start(fs, st);
        for (int i = 0; i < fs; i++) write_filter(filt_q[i]);
        if (pm) begin
            write_psum(16'd100);
            write_psum(16'd200);
        end
        send_row();
        for (int j = 0; j < exp_q.size(); j++) begin
            read_result(got);
            check($sformatf("%s_res%0d", name, j), {16'd0, got}, {16'd0, exp_q[j]});
            if (j == 0) check($sformatf("%s_valid", name), {31'd0, result_buffer_valid}, 1);
        end
        repeat (30) @(negedge clk);
        check($sformatf("%s_drained", name), {31'd0, result_buffer_empty}, 1);
        check($sformatf("%s_idle_stall", name), {31'd0, stall_signal}, 1);
    endtask

    initial begin
        logic [15:0] got;

        apply_reset();
        check("rst_stall", {31'd0, stall_signal}, 0);
        check("rst_out", {16'd0, result_buffer_out}, 0);
        check("rst_valid", {31'd0, result_buffer_valid}, 0);
        check("rst_empty", {31'd0, result_buffer_empty}, 1);
        check("rst_if_full", {31'd0, IFmap_buffer_full}, 0);
        check("rst_f_full", {31'd0, filter_buffer_full}, 0);
        check("rst_if_ready", {31'd0, IFmap_buffer_ready}, 1);
        check("rst_f_ready", {31'd0, filter_buffer_ready}, 1);
        check("rst_psum_ready", {31'd0, psum_buffer_ready}, {31'd0, PSUM_BUILT});

        // IFmap FIFO fills at 12 words without a start; 13th write is dropped.
        for (int i = 0; i < 12; i++) begin
            pulse_ifmap(IW'($urandom_range(0, 65535)));
            if (i == 10) check("fill_11_not_full", {31'd0, IFmap_buffer_full}, 0);
        end
        check("fill_12_full", {31'd0, IFmap_buffer_full}, 1);
        check("fill_12_ready", {31'd0, IFmap_buffer_ready}, 0);
        pulse_ifmap(IW'(16'h1234));
        check("fill_13_full", {31'd0, IFmap_buffer_full}, 1);

        // Enable held high for two cycles stores exactly one word.
        apply_reset();
        @(negedge clk);
        IFmap_buffer_in = IW'(16'h0055);
        IFmap_buffer_write_enable = 1'b1;
        repeat (2) @(negedge clk);
        IFmap_buffer_write_enable = 1'b0;
        for (int i = 0; i < 10; i++) pulse_ifmap(IW'(i));
        check("hold_11_not_full", {31'd0, IFmap_buffer_full}, 0);
        pulse_ifmap(IW'(16'h0077));
        check("hold_12_full", {31'd0, IFmap_buffer_full}, 1);

        set_basic_data();
        run_case("basic", 4, 4, 1'b0);
        run_case("stride1", 4, 1, 1'b0);
        run_case("stride0", 4, 0, 1'b0);

        filt_q = '{16'hFFFF};
        row_q  = '{16'hFFFF};
        run_case("trunc", 1, 1, 1'b0);

        set_basic_data();
        row_q = '{16'd5, 16'd6, 16'd7};
        run_case("short_row", 4, 1, 1'b0);
        run_case("fsize0", 0, 1, 1'b0);

`ifdef CNN_PSUM_EN
        apply_reset();
        set_basic_data();
        psum_q = '{16'd100, 16'd200};
        build_expected(4, 4, 1'b1);
        psum_mode = 1'b1;
        pulse_start(4, 4);
        for (int i = 0; i < 4; i++) write_filter(filt_q[i]);
        send_row();
        repeat (40) @(negedge clk);
        check("psum_wait_stall", {31'd0, stall_signal}, 1);
        check("psum_wait_empty", {31'd0, result_buffer_empty}, 1);
        write_psum(psum_q[0]);
        read_result(got);
        check("psum_res0", {16'd0, got}, {16'd0, exp_q[0]});
        repeat (20) @(negedge clk);
        check("psum_wait_stall2", {31'd0, stall_signal}, 1);
        write_psum(psum_q[1]);
        read_result(got);
        check("psum_res1", {16'd0, got}, {16'd0, exp_q[1]});
`else
        set_basic_data();
        run_case("psum_ignored", 4, 4, 1'b1);
`endif

        for (int r = 0; r < 10; r++) begin
            int fs;
            int len;
            fs  = $urandom_range(1, 4);
            len = $urandom_range(1, 12);
            filt_q.delete();
            row_q.delete();
            for (int i = 0; i < fs; i++) filt_q.push_back(16'($urandom_range(0, 65535)));
            for (int i = 0; i < len; i++) row_q.push_back(16'($urandom_range(0, 65535)));
            run_case($sformatf("rand%0d", r), fs, $urandom_range(0, 3), PSUM_BUILT ? 1'b0 : 1'($urandom_range(0, 1)));
        end

        // Reset while the engine is between windows discards everything.
        apply_reset();
        set_basic_data();
        pulse_start(4, 1);
        for (int i = 0; i < 4; i++) write_filter(filt_q[i]);
        send_row();
        read_result(got);
        check("midrst_first", {16'd0, got}, 16'd10);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_empty", {31'd0, result_buffer_empty}, 1);
        check("midrst_valid", {31'd0, result_buffer_valid}, 0);
        check("midrst_out", {16'd0, result_buffer_out}, 0);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        check("midrst_no_results", {31'd0, result_buffer_empty}, 1);
        check("midrst_no_stall", {31'd0, stall_signal}, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
